desarme_senha: RTL and testbench

//  Defuse-code entry FSM: the other end of the countdown timer. Collects BCD digits

---
 rtl/desarme_senha.sv | 160 ++++++++++++++++
 tb/tb_desarme_senha.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/desarme_senha.sv
// desarme_senha: defuse-code entry FSM, counterpart of the countdown timer.
// Define LOCKOUT_EN to add an input-ignore window after each non-final wrong code.
module desarme_senha #(
    parameter int          N_DIGITOS      = 4,
    parameter logic [31:0] SENHA          = 32'h1234,
    parameter int          MAX_TENTATIVAS = 3,
    parameter int          LOCKOUT_CICLOS = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] digito,
    input  logic       digito_valido,
    input  logic       limpar,
    input  logic       explodiu,
    output logic       desarmada,
    output logic       detonar,
    output logic       erro,
    output logic [3:0] tentativas,
    output logic [3:0] n_entrados,
    output logic       ocupado
);
    localparam logic [3:0] TENT_INI = 4'(MAX_TENTATIVAS);
    localparam logic [3:0] ULTIMO   = 4'(N_DIGITOS - 1);

    if (N_DIGITOS < 1 || N_DIGITOS > 8 || MAX_TENTATIVAS < 1 || MAX_TENTATIVAS > 15 ||
        LOCKOUT_CICLOS < 1) begin : g_param_err
        $error("desarme_senha: parameter out of range");
    end

`ifdef LOCKOUT_EN
    typedef enum logic [2:0] {IDLE, ENTRADA, CHECA, LOCKOUT, DESARMADA, EXPLODIDA} estado_t;
    localparam int               CNT_W   = (LOCKOUT_CICLOS > 1) ? $clog2(LOCKOUT_CICLOS) : 1;
    localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(LOCKOUT_CICLOS - 1);
    logic [CNT_W-1:0] cnt;
`else
    typedef enum logic [2:0] {IDLE, ENTRADA, CHECA, DESARMADA, EXPLODIDA} estado_t;
`endif

    estado_t estado, estado_n;
    logic [3:0] n_n, tent_n;
    logic       des_n, det_n, erro_n, grava, confere;

    logic [N_DIGITOS-1:0][3:0] digitos;
    logic [N_DIGITOS-1:0]      dig_ok;

    // First key typed is the most significant used nibble, so 1,2,3,4 matches 16'h1234.
    for (genvar i = 0; i < N_DIGITOS; i++) begin : g_cmp
        assign dig_ok[i] = (digitos[i] == SENHA[4*(N_DIGITOS-1-i) +: 4]);
    end
    assign confere = &dig_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digitos <= '0;
        end else if (grava) begin
            for (int i = 0; i < N_DIGITOS; i++)
                if (n_entrados == 4'(i)) digitos[i] <= digito;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado     <= IDLE;
            n_entrados <= '0;
            tentativas <= TENT_INI;
            desarmada  <= 1'b0;
            detonar    <= 1'b0;
            erro       <= 1'b0;
        end else begin
            estado     <= estado_n;
            n_entrados <= n_n;
            tentativas <= tent_n;
            desarmada  <= des_n;
            detonar    <= det_n;
            erro       <= erro_n;
        end
    end

`ifdef LOCKOUT_EN
    // Loaded on entry so LOCKOUT lasts exactly LOCKOUT_CICLOS cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (estado_n == LOCKOUT && estado != LOCKOUT)
            cnt <= CNT_INI;
        else if (estado == LOCKOUT && cnt != '0)
            cnt <= cnt - 1'b1;
    end
    assign ocupado = (estado == LOCKOUT);
`else
    assign ocupado = 1'b0;
`endif

    always_comb begin
        estado_n = estado;
        n_n      = n_entrados;
        tent_n   = tentativas;
        des_n    = desarmada;
        det_n    = detonar;
        erro_n   = 1'b0;
        grava    = 1'b0;
        if (start) begin
            estado_n = ENTRADA;
            n_n      = '0;
            tent_n   = TENT_INI;
            des_n    = 1'b0;
            det_n    = 1'b0;
        end else begin
            case (estado)
                ENTRADA: begin
                    if (explodiu) begin
                        estado_n = EXPLODIDA;
                    end else if (limpar) begin
                        n_n = '0;
                    end else if (digito_valido && digito <= 4'd9) begin
                        grava = 1'b1;
                        if (n_entrados == ULTIMO) begin
                            n_n      = '0;
                            estado_n = CHECA;
                        end else begin
                            n_n = n_entrados + 4'd1;
                        end
                    end
                end
                CHECA: begin
                    if (explodiu) begin
                        estado_n = EXPLODIDA;
                    end else if (confere) begin
                        estado_n = DESARMADA;
                        des_n    = 1'b1;
                    end else begin
                        erro_n = 1'b1;
                        if (tentativas > 4'd1) begin
                            tent_n = tentativas - 4'd1;
`ifdef LOCKOUT_EN
                            estado_n = LOCKOUT;
`else
                            estado_n = ENTRADA;
`endif
                        end else begin
                            tent_n   = '0;
                            det_n    = 1'b1;
                            estado_n = EXPLODIDA;
                        end
                    end
                end
`ifdef LOCKOUT_EN
                LOCKOUT: begin
                    if (explodiu)
                        estado_n = EXPLODIDA;
                    else if (cnt == '0)
                        estado_n = ENTRADA;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_desarme_senha.sv
// Scoreboard bench for desarme_senha: each submitted code queues its expected outcome,
// a negedge monitor pops it when erro or a desarmada rise appears.
module tb_desarme_senha;
    logic       clk = 1'b0;
    logic       reset, start, digito_valido, limpar, explodiu;
    logic [3:0] digito;
    logic       desarmada, detonar, erro, ocupado;
    logic [3:0] tentativas, n_entrados;

    int n_chk = 0;
    int n_pass = 0;

`ifdef LOCKOUT_EN
    localparam int LOCK = 8;
`else
    localparam int LOCK = 0;
`endif

    typedef struct { int kind; int tent; int det; } ev_t;   // kind 1 = erro, 2 = desarmada
    ev_t  sb[$];
    ev_t  ev;
    logic des_q = 1'b0;

    always #5 clk = ~clk;

    desarme_senha #(.N_DIGITOS(4), .SENHA(32'h1234), .MAX_TENTATIVAS(3), .LOCKOUT_CICLOS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .digito(digito), .digito_valido(digito_valido),
        .limpar(limpar), .explodiu(explodiu), .desarmada(desarmada), .detonar(detonar),
        .erro(erro), .tentativas(tentativas), .n_entrados(n_entrados), .ocupado(ocupado)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (erro || (desarmada && !des_q)) begin
            if (sb.size() == 0) begin
                chk("sb_inesperado", int'({erro, desarmada}), 0);
            end else begin
                ev = sb.pop_front();
                chk("sb_tipo", erro ? 1 : 2, ev.kind);
                chk("sb_tent", int'(tentativas), ev.tent);
                chk("sb_det", int'(detonar), ev.det);
            end
        end
        des_q = desarmada;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tecla(input logic [3:0] d);
        digito        = d;
        digito_valido = 1'b1;
        tick();
        digito_valido = 1'b0;
    endtask

    task automatic codigo(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) tecla(c[4*i +: 4]);
    endtask

    task automatic pulso_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called just after the erro edge; counts ocupado cycles, optionally keying during lockout.
    task automatic espera_lockout(input string tag, input bit injeta);
        int cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (ocupado) cnt++;
            digito        = 4'd5;
            digito_valido = injeta && (i < 3);
            tick();
        end
        digito_valido = 1'b0;
        chk({tag, "_ocupado"}, cnt, LOCK);
        chk({tag, "_n"}, int'(n_entrados), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; digito = '0; digito_valido = 1'b0; limpar = 1'b0; explodiu = 1'b0;
        repeat (2) tick();
        chk("rst_des", int'(desarmada), 0);
        chk("rst_det", int'(detonar), 0);
        chk("rst_erro", int'(erro), 0);
        chk("rst_tent", int'(tentativas), 3);
        chk("rst_n", int'(n_entrados), 0);
        chk("rst_ocup", int'(ocupado), 0);
        reset = 1'b0;
        tick();
        tecla(4'd1);
        chk("idle_n", int'(n_entrados), 0);

        // T1: correct code, 2-cycle latency
        pulso_start();
        sb.push_back('{kind: 2, tent: 3, det: 0});
        codigo(16'h1234);
        chk("t1_lat1", int'(desarmada), 0);
        tick();
        chk("t1_lat2", int'(desarmada), 1);
        chk("t1_tent", int'(tentativas), 3);
        explodiu = 1'b1;
        tick();
        explodiu = 1'b0;
        tecla(4'd1);
        chk("t1_hold", int'(desarmada), 1);
        chk("t1_n", int'(n_entrados), 0);

        // T2: wrong code, lockout ignores keys
        pulso_start();
        sb.push_back('{kind: 1, tent: 2, det: 0});
        codigo(16'h1235);
        tick();
        chk("t2_erro", int'(erro), 1);
        chk("t2_tent", int'(tentativas), 2);
        espera_lockout("t2", LOCK != 0);

        // T3: exhaust attempts
        sb.push_back('{kind: 1, tent: 1, det: 0});
        codigo(16'h9999);
        tick();
        chk("t3_tent1", int'(tentativas), 1);
        espera_lockout("t3", 1'b0);
        sb.push_back('{kind: 1, tent: 0, det: 1});
        codigo(16'h0000);
        tick();
        chk("t3_tent0", int'(tentativas), 0);
        chk("t3_det", int'(detonar), 1);
        codigo(16'h1234);
        repeat (3) tick();
        chk("t3_des", int'(desarmada), 0);
        chk("t3_det_hold", int'(detonar), 1);
        pulso_start();
        chk("t3_det_clr", int'(detonar), 0);
        chk("t3_tent_rst", int'(tentativas), 3);
        chk("t3_n_rst", int'(n_entrados), 0);

        // T4: limpar and invalid digits
        tecla(4'd1);
        tecla(4'd2);
        chk("t4_n2", int'(n_entrados), 2);
        tecla(4'hA);
        chk("t4_bcd", int'(n_entrados), 2);
        limpar = 1'b1;
        tick();
        chk("t4_limpar", int'(n_entrados), 0);
        tecla(4'd1);
        limpar = 1'b0;
        chk("t4_limpar_pri", int'(n_entrados), 0);
        sb.push_back('{kind: 2, tent: 3, det: 0});
        codigo(16'h1234);
        tick();
        chk("t4_des", int'(desarmada), 1);

        // T5: explodiu with the last digit, then during CHECA
        pulso_start();
        tecla(4'd1);
        tecla(4'd2);
        tecla(4'd3);
        explodiu = 1'b1;
        tecla(4'd4);
        explodiu = 1'b0;
        repeat (3) tick();
        chk("t5_des", int'(desarmada), 0);
        chk("t5_n", int'(n_entrados), 3);
        pulso_start();
        codigo(16'h1234);
        explodiu = 1'b1;
        tick();
        explodiu = 1'b0;
        repeat (2) tick();
        chk("t5_checa_des", int'(desarmada), 0);

        // T6: async reset mid-entry, start from DESARMADA
        pulso_start();
        sb.push_back('{kind: 1, tent: 2, det: 0});
        codigo(16'h4321);
        tick();
        espera_lockout("t6", 1'b0);
        tecla(4'd1);
        tecla(4'd2);
        chk("t6_n2", int'(n_entrados), 2);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_n", int'(n_entrados), 0);
        chk("t6_rst_tent", int'(tentativas), 3);
        chk("t6_rst_des", int'(desarmada), 0);
        chk("t6_rst_det", int'(detonar), 0);
        chk("t6_rst_erro", int'(erro), 0);
        chk("t6_rst_ocup", int'(ocupado), 0);
        tick();
        reset = 1'b0;
        tecla(4'd1);
        chk("t6_idle_n", int'(n_entrados), 0);
        pulso_start();
        sb.push_back('{kind: 2, tent: 3, det: 0});
        codigo(16'h1234);
        tick();
        chk("t6_des", int'(desarmada), 1);
        pulso_start();
        chk("t6_des_clr", int'(desarmada), 0);
        chk("t6_n_clr", int'(n_entrados), 0);

        repeat (3) tick();
        chk("sb_vazio", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
